// File: rtl/usb_tx_controller_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// usb_tx_controller_if : FT245 transmit-side bus bundle          rev 1.0
// ------------------------------------------------------------------------
interface usb_tx_controller_if #(
  parameter int FIFO_AW = 3
);
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             txe_n_raw;
  logic             rx_active;
  logic [7:0]       data_out;
  logic             data_oe;
  logic             wr_n;
  logic [FIFO_AW:0] fifo_count;
  logic             busy;

  modport master (
    output tx_data, tx_valid, txe_n_raw, rx_active,
    input  tx_ready, data_out, data_oe, wr_n, fifo_count, busy
  );

  modport slave (
    input  tx_data, tx_valid, txe_n_raw, rx_active,
    output tx_ready, data_out, data_oe, wr_n, fifo_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_controller.sv
`default_nettype none
// ------------------------------------------------------------------------
// usb_tx_controller : byte FIFO + txe_n/wr_n write sequencer    rev 1.0
// ------------------------------------------------------------------------
module usb_tx_controller #(
  parameter int FIFO_AW       = 3,
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 1
) (
  input  wire logic          clk,
  input  wire logic          reset,
  usb_tx_controller_if.slave bus
);
  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam int               CNT_W   = 8;
  localparam logic [FIFO_AW:0] C_DEPTH = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  logic             r_txe_meta;
  logic             r_txe_s;
  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0] r_count;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data_out;
  logic             r_data_oe;
  logic             r_wr_n;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_tx_ready;

  // txe_n is driven by the USB chip on its own timing; preset to "full".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txe_meta <= 1'b1;
      r_txe_s    <= 1'b1;
    end else begin
      r_txe_meta <= bus.txe_n_raw;
      r_txe_s    <= r_txe_meta;
    end
  end

  assign w_tx_ready = (r_count != C_DEPTH);
  assign w_push     = bus.tx_valid && w_tx_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Only SETUP honours backpressure; once wr_n has fallen the cycle must finish.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !r_txe_s && !bus.rx_active) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
          w_load      = 1'b1;
        end
      end
      S_SETUP: begin
        if (r_txe_s || bus.rx_active) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_STROBE;
          w_cnt_nxt   = CNT_W'(STROBE_CYCLES - 1);
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_pop       = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data_out <= 8'h00;
      r_data_oe  <= 1'b0;
      r_wr_n     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wr_n    <= (w_state_nxt != S_STROBE);
      r_data_oe <= (w_state_nxt != S_IDLE);
      if (w_load) r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign bus.tx_ready   = w_tx_ready;
  assign bus.fifo_count = r_count;
  assign bus.data_out   = r_data_out;
  assign bus.data_oe    = r_data_oe;
  assign bus.wr_n       = r_wr_n;
  assign bus.busy       = (r_state != S_IDLE);
endmodule
`default_nettype wire
